// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions for the 7-segment scan controller.
// Blanking patterns, FSM state type and parameter legality check.
package seg_scan_ctrl_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic bit params_ok(input int n, input int r, input int b);
        return (n >= 1) && (n <= 8) && (b >= 1) && (r > b);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Ports: hex (4-bit nibble in), seg (7 active-low segment lines out).
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for common-anode 7-segment digits.
// Ports: clk, rst_n, data_in/dp_in/load (display write), lz_en,
//        an/seg/dp (active-low pins), frame_tick (digit-0 slot start).
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_bad_params
        $error("seg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
    end

    logic [DW-1:0]         pend_q, disp_q, disp_n;
    logic [NUM_DIGITS-1:0] pdp_q, ddp_q, ddp_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    scan_state_t           st_q, st_n;
    logic                  slot_end, frame_end;
    logic                  zero_run, sup, lit, dp_bit;
    logic [3:0]            nib;
    logic [6:0]            dec;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n, ft_n, ft_q;

    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_n     = slot_end ? '0 : cnt_q + 1'b1;
        idx_n     = idx_q;
        if (slot_end) begin
            idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load landing on the boundary bypasses pending.
        disp_n = disp_q;
        ddp_n  = ddp_q;
        if (frame_end) begin
            disp_n = load ? data_in : pend_q;
            ddp_n  = load ? dp_in : pdp_q;
        end

        st_n = st_q;
        case (st_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) st_n = ST_SHOW;
            ST_SHOW:  if (slot_end) st_n = ST_BLANK;
            default:  st_n = ST_BLANK;
        endcase

        // zero_run stays set while every nibble from the top down is 0.
        zero_run = 1'b1;
        nib      = 4'h0;
        sup      = 1'b0;
        dp_bit   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_n[4*i +: 4] == 4'h0);
            if (idx_n == IDX_W'(i)) begin
                nib    = disp_n[4*i +: 4];
                dp_bit = ddp_n[i];
                sup    = lz_en && zero_run && !ddp_n[i] && (i != 0);
            end
        end
        lit = (st_n == ST_SHOW) && !sup;
        ft_n = (cnt_n == '0) && (idx_n == '0);
    end

    hex_to_7seg u_dec (
        .hex (nib),
        .seg (dec)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n[i] = !(lit && (idx_n == IDX_W'(i)));
        end
        seg_n = lit ? dec : SEG_OFF;
        dp_n  = lit ? ~dp_bit : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            pdp_q  <= '0;
            disp_q <= '0;
            ddp_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            st_q   <= ST_BLANK;
            an     <= AN_OFF[NUM_DIGITS-1:0];
            seg    <= SEG_OFF;
            dp     <= 1'b1;
            // Reset state is cnt=0/idx=0, so the first cycle is a tick.
            ft_q   <= 1'b1;
        end else begin
            if (load) begin
                pend_q <= data_in;
                pdp_q  <= dp_in;
            end
            disp_q <= disp_n;
            ddp_q  <= ddp_n;
            cnt_q  <= cnt_n;
            idx_q  <= idx_n;
            st_q   <= st_n;
            an     <= an_n;
            seg    <= seg_n;
            dp     <= dp_n;
            ft_q   <= ft_n;
        end
    end

    assign frame_tick = ft_q & rst_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots).
// Vector table, hand sequences and a random run against a model.
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = R * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    int tests = 0;
    int fails = 0;
    int t = 0;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_lz;
    logic [6:0]  segtab [16];

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic        lz;
        logic [3:0]  lit;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
        end
    endtask

    // Expected {an,seg,dp} from edge count and the modelled display.
    function automatic logic [11:0] model_out();
        int c, d;
        logic [3:0] nb;
        logic sp, lt;
        c  = t % R;
        d  = (t / R) % N;
        nb = m_disp[4*d +: 4];
        sp = m_lz && (d != 0) && ((m_disp >> (4*d)) == 16'h0) && !m_ddp[d];
        lt = (c >= B) && !sp;
        if (lt) return {~(4'b0001 << d), segtab[nb], ~m_ddp[d]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic edge_chk();
        @(posedge clk);
        if (load) begin
            m_pend = data_in;
            m_pdp  = dp_in;
        end
        m_lz = lz_en;
        t++;
        if (t % F == 0) begin
            m_disp = m_pend;
            m_ddp  = m_pdp;
        end
        #1;
        check("scan", {an, seg, dp, frame_tick}, {model_out(), (t % F == 0)});
    endtask

    task automatic run_until(input int c, input int d);
        int n;
        n = 0;
        while (!((t % R == c) && ((t / R) % N == d)) && n < 200) begin
            edge_chk();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL run_until timeout got %0d edges want <200", n);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        edge_chk();
        load    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        lz_en = 1'b0;
        #12;
        check("reset_out", {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst_n  = 1'b1;
        t      = 0;
        m_pend = '0;
        m_disp = '0;
        m_pdp  = '0;
        m_ddp  = '0;
        m_lz   = 1'b0;
        #1;
        check("cycle0", {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b1});
    endtask

    task automatic scan_test1(input string tag);
        repeat (40) begin
            edge_chk();
            if (t == 1) check({tag, "_e1"}, {an, seg}, {4'hF, 7'h7F});
            if (t == 2) check({tag, "_e2"}, {an, seg}, {4'hE, 7'h01});
            if (t == 7) check({tag, "_e7"}, {an, seg}, {4'hE, 7'h01});
            if (t == 8) check({tag, "_e8"}, an, 4'hF);
            if (t == 10) check({tag, "_e10"}, an, 4'hD);
            if (t == 31) check({tag, "_ft31"}, frame_tick, 1'b0);
            if (t == 32) check({tag, "_ft32"}, frame_tick, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an;
        logic [15:0] mask;

        segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        vecs[0] = '{16'h1230, 4'b0000, 1'b0, 4'b1111,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b0000001}, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011,
                    {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0100, 1'b1, 4'b0101,
                    {7'h7F, 7'b0000001, 7'h7F, 7'b0000001}, 4'b1011};
        vecs[4] = '{16'hABCD, 4'b1010, 1'b1, 4'b1111,
                    {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'b0101};
        vecs[5] = '{16'h00F0, 4'b1000, 1'b1, 4'b1011,
                    {7'b0000001, 7'h7F, 7'b0111000, 7'b0000001}, 4'b0111};
        vecs[6] = '{16'h0008, 4'b0000, 1'b0, 4'b1111,
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000}, 4'b1111};

        do_reset();
        scan_test1("t1");

        for (int k = 0; k < 7; k++) begin
            lz_en = vecs[k].lz;
            run_until(3, 1);
            pulse_load(vecs[k].data, vecs[k].dpv);
            if (k == 0) begin
                run_until(5, 3);
                check("no_tear", {an, seg}, {4'h7, 7'b0000001});
            end
            run_until(0, 0);
            for (int d = 0; d < N; d++) begin
                run_until(5, d);
                exp_an = vecs[k].lit[d] ? ~(4'b0001 << d) : 4'hF;
                check($sformatf("vec%0d_d%0d", k, d), {an, seg, dp},
                      {exp_an, vecs[k].seg[7*d +: 7], vecs[k].dpo[d]});
            end
        end

        lz_en = 1'b0;
        run_until(3, 0);
        pulse_load(16'h1111, 4'h0);
        run_until(2, 2);
        pulse_load(16'h2222, 4'h0);
        run_until(0, 0);
        for (int d = 0; d < N; d++) begin
            run_until(5, d);
            check($sformatf("last_wins_d%0d", d), {an, seg},
                  {~(4'b0001 << d), 7'b0010010});
        end

        run_until(R - 1, N - 1);
        pulse_load(16'h4321, 4'h0);
        run_until(5, 0);
        check("bnd_load_d0", {an, seg}, {4'hE, 7'b1001111});
        run_until(5, 3);
        check("bnd_load_d3", {an, seg}, {4'h7, 7'b1001100});

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            data_in = 16'($urandom) & mask;
            dp_in   = 4'($urandom) & 4'($urandom);
            load    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            edge_chk();
            load = 1'b0;
        end

        do_reset();
        repeat (13) edge_chk();
        check("pre_rst_an", an, 4'hD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        do_reset();
        scan_test1("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
